// File: rtl/i_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i_fetch_pkg
//  Description : Shared types for the bfcpu instruction fetch initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package i_fetch_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/i_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : i_fetch_fifo
//  Description : Synchronous show-ahead FIFO; flush overrides push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module i_fetch_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign w_push_ok = i_push && (r_count != c_CNT_W'(DEPTH));
    assign w_pop_ok  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_push_ok) - c_CNT_W'(w_pop_ok);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/i_fetch_icecream_v1.sv
`default_nettype none
// ============================================================================
//  Module      : i_fetch_icecream_v1
//  Description : Instruction fetch initiator with prefetch FIFO and redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module i_fetch_icecream_v1
    import i_fetch_pkg::*;
#(
    parameter int I_ADDR_WIDTH = 16,
    parameter int I_MEM_LENGTH = 1024,
    parameter int FIFO_DEPTH   = 4,
    parameter int RESET_PC     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    i_req,
    output logic [I_ADDR_WIDTH-1:0] i_addr,
    input  logic                    i_ack,
    input  logic [7:0]              i_rdata,
    output logic                    ins_valid,
    output logic [7:0]              ins_data,
    output logic [I_ADDR_WIDTH-1:0] ins_addr,
    input  logic                    ins_ready,
    input  logic                    jmp_valid,
    input  logic [I_ADDR_WIDTH-1:0] jmp_addr,
    output logic                    fetch_end
);

    localparam int                    c_CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int                    c_ENTRY_W  = I_ADDR_WIDTH + c_DATA_W;
    localparam logic [I_ADDR_WIDTH-1:0] c_END_PC   = I_ADDR_WIDTH'(I_MEM_LENGTH);
    localparam logic [I_ADDR_WIDTH-1:0] c_RESET_PC = I_ADDR_WIDTH'(RESET_PC);
    localparam logic [c_CNT_W-1:0]      c_DEPTH    = c_CNT_W'(FIFO_DEPTH);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [I_ADDR_WIDTH-1:0] r_pc;
    logic [c_CNT_W-1:0]      w_count;
    logic [c_ENTRY_W-1:0]    w_head;
    logic                    w_can_fetch;
    logic                    w_accept;

    assign w_can_fetch = (w_count < c_DEPTH) && (r_pc != c_END_PC) && !jmp_valid;
    // A redirect voids an ack arriving in the same cycle.
    assign w_accept    = (r_state == REQ) && i_ack && !jmp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= c_RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (jmp_valid) begin
                r_pc <= jmp_addr;
            end else if (w_accept) begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, GAP: begin
                if (jmp_valid) begin
                    w_state_nxt = GAP;
                end else if (w_can_fetch) begin
                    w_state_nxt = REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (jmp_valid || i_ack) begin
                    w_state_nxt = GAP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    i_fetch_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_pop   (ins_ready),
        .i_flush (jmp_valid),
        .i_wdata ({r_pc, i_rdata}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign i_req     = (r_state == REQ);
    assign i_addr    = r_pc;
    assign ins_valid = (w_count != '0);
    assign ins_addr  = w_head[c_ENTRY_W-1:c_DATA_W];
    assign ins_data  = w_head[c_DATA_W-1:0];
    assign fetch_end = (r_state != REQ) && (r_pc == c_END_PC);

endmodule
`default_nettype wire

// File: tb/tb_i_fetch_icecream_v1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i_fetch_icecream_v1
//  Description : Bench for i_fetch_icecream_v1 with memory responder and model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i_fetch_icecream_v1;
    import i_fetch_pkg::*;

    localparam int AW    = 16;
    localparam int LEN   = 6;
    localparam int DEPTH = 4;
    localparam int RPC   = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack = 1'b0;
    logic [7:0]    i_rdata = 8'h00;
    logic          ins_valid;
    logic [7:0]    ins_data;
    logic [AW-1:0] ins_addr;
    logic          ins_ready = 1'b0;
    logic          jmp_valid = 1'b0;
    logic [AW-1:0] jmp_addr = '0;
    logic          fetch_end;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i_fetch_icecream_v1 #(
        .I_ADDR_WIDTH (AW),
        .I_MEM_LENGTH (LEN),
        .FIFO_DEPTH   (DEPTH),
        .RESET_PC     (RPC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .ins_valid (ins_valid),
        .ins_data  (ins_data),
        .ins_addr  (ins_addr),
        .ins_ready (ins_ready),
        .jmp_valid (jmp_valid),
        .jmp_addr  (jmp_addr),
        .fetch_end (fetch_end)
    );

    // Memory responder: ack registered from req, data valid with ack.
    logic [7:0] mem [256];
    bit         lat_rand = 1'b0;

    always @(posedge clk) begin
        i_ack   <= i_req && !i_ack && (!lat_rand || ($urandom_range(0, 2) == 0));
        i_rdata <= mem[i_addr[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte stream = consecutive addresses from pc, restarted on redirect.
    fetch_entry_t  q[$];
    fetch_entry_t  pops[$];
    fetch_entry_t  e;
    logic [AW-1:0] m_pc   = AW'(RPC);
    bit            p_req  = 1'b0;
    bit            p_ack  = 1'b0;
    bit            p_jmp  = 1'b0;
    bit            p_rst  = 1'b1;
    logic [AW-1:0] p_addr = '0;
    int            n_push = 0;

    always @(negedge clk) begin
        chk("ins_valid", ins_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("ins_addr", ins_addr, q[0].addr);
            chk("ins_data", ins_data, q[0].data);
        end
        chk("i_addr", i_addr, m_pc);
        chk("fetch_end", fetch_end, !i_req && (m_pc == AW'(LEN)));
        chk("req_after_ack", i_req && p_req && p_ack, 1'b0);
        if (i_req && p_req) chk("addr_stable", i_addr, p_addr);
        if (p_jmp || p_rst) chk("req_low_after_redirect", i_req, 1'b0);
        if (i_req && !p_req) begin
            chk("req_rise_space", q.size() < DEPTH, 1'b1);
            chk("req_rise_not_end", m_pc != AW'(LEN), 1'b1);
        end

        p_req  = i_req;
        p_ack  = i_ack;
        p_addr = i_addr;
        p_jmp  = jmp_valid;
        p_rst  = rst;
        if (rst) begin
            q.delete();
            m_pc = AW'(RPC);
        end else if (jmp_valid) begin
            q.delete();
            m_pc = jmp_addr;
        end else begin
            if (ins_ready && q.size() > 0) begin
                pops.push_back(q[0]);
                void'(q.pop_front());
            end
            if (i_req && i_ack) begin
                chk("no_overflow", q.size() < DEPTH, 1'b1);
                e.addr = m_pc;
                e.data = mem[m_pc[7:0]];
                q.push_back(e);
                m_pc = m_pc + 1'b1;
                n_push++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit rdy);
        rst       = 1'b1;
        jmp_valid = 1'b0;
        ins_ready = rdy;
        tick();
        tick();
        rst = 1'b0;
        pops.delete();
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!i_req && n < 20) begin
            tick();
            n++;
        end
        if (!i_req) chk({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    logic [5:0] req_tr;
    logic [5:0] vld_tr;
    int         n0;
    int         nreq;
    int         budget;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'h3E;
        mem[1] = 8'h2B;
        mem[2] = 8'h5B;
        mem[3] = 8'h5D;

        // 1: reset release, request pulse shape and first stream bytes
        do_reset(1'b1);
        chk("reset_req", i_req, 1'b0);
        chk("reset_valid", ins_valid, 1'b0);
        chk("reset_addr", i_addr, RPC);
        chk("reset_fetch_end", fetch_end, 1'b0);
        for (int c = 0; c < 6; c++) begin
            req_tr[5-c] = i_req;
            vld_tr[5-c] = ins_valid;
            tick();
        end
        chk("t1_req_pulses", req_tr, 6'b011011);
        chk("t1_first_valid", vld_tr, 6'b000100);
        budget = 0;
        while (pops.size() < 4 && budget < 40) begin
            tick();
            budget++;
        end
        if (pops.size() < 4) chk("t1_timeout", 1'b0, 1'b1);
        else begin
            chk("t1_stream", {pops[0].addr[3:0], pops[0].data, pops[1].addr[3:0], pops[1].data},
                32'h03E_12B);
            chk("t1_stream_hi", {pops[2].addr[3:0], pops[2].data, pops[3].addr[3:0], pops[3].data},
                32'h25B_35D);
        end

        // 2: decoder stalled, FIFO fills with exactly four bytes
        do_reset(1'b0);
        n0 = n_push;
        for (int c = 0; c < 30; c++) tick();
        chk("t2_fetched", n_push - n0, 4);
        chk("t2_head_addr", ins_addr, 0);
        nreq = 0;
        for (int c = 0; c < 15; c++) begin
            nreq += int'(i_req);
            tick();
        end
        chk("t2_req_while_full", nreq, 0);
        ins_ready = 1'b1;
        wait_req("t2_resume");
        chk("t2_resume_addr", i_addr, 4);

        // 3: redirect on an ack cycle
        do_reset(1'b1);
        budget = 0;
        while (!i_ack && budget < 20) begin
            tick();
            budget++;
        end
        chk("t3_ack_seen", i_ack, 1'b1);
        jmp_valid = 1'b1;
        jmp_addr  = 16'h0010;
        tick();
        jmp_valid = 1'b0;
        pops.delete();
        chk("t3_flushed", ins_valid, 1'b0);
        chk("t3_req_low", i_req, 1'b0);
        wait_req("t3_rereq");
        chk("t3_req_addr", i_addr, 16'h0010);
        budget = 0;
        while (pops.size() == 0 && budget < 20) begin
            tick();
            budget++;
        end
        if (pops.size() == 0) chk("t3_pop_timeout", 1'b0, 1'b1);
        else begin
            chk("t3_first_addr", pops[0].addr, 16'h0010);
            chk("t3_first_data", pops[0].data, mem[16]);
        end

        // 4: end of program and redirect out of it
        do_reset(1'b1);
        budget = 0;
        while (!fetch_end && budget < 60) begin
            tick();
            budget++;
        end
        chk("t4_fetch_end", fetch_end, 1'b1);
        nreq = 0;
        for (int c = 0; c < 15; c++) begin
            nreq += int'(i_req);
            tick();
        end
        chk("t4_no_req_at_end", nreq, 0);
        chk("t4_end_held", fetch_end, 1'b1);
        chk("t4_pop_count", pops.size(), 6);
        if (pops.size() > 0) chk("t4_last_addr", pops[pops.size()-1].addr, 5);
        jmp_valid = 1'b1;
        jmp_addr  = 16'd2;
        tick();
        jmp_valid = 1'b0;
        chk("t4_end_cleared", fetch_end, 1'b0);
        wait_req("t4_rereq");
        chk("t4_rereq_addr", i_addr, 2);

        // 5: reset during an outstanding request
        do_reset(1'b1);
        wait_req("t5_req");
        rst = 1'b1;
        tick();
        chk("t5_req", i_req, 1'b0);
        chk("t5_valid", ins_valid, 1'b0);
        chk("t5_addr", i_addr, RPC);
        rst = 1'b0;

        // Randomized traffic with variable memory latency
        lat_rand = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            ins_ready = ($urandom_range(0, 3) != 0);
            jmp_valid = ($urandom_range(0, 29) == 0);
            jmp_addr  = ($urandom_range(0, 7) == 0) ? 16'hFFFE : AW'($urandom_range(0, 40));
            rst       = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst       = 1'b0;
        jmp_valid = 1'b0;
        for (int c = 0; c < 10; c++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
